mux_stream: RTL and testbench



---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_stream_rr_arbiter.sv | 42 ++++
 rtl/mux_stream.sv | 83 ++++++++
 tb/tb_mux_stream.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the streaming multiplexer.
// Imported by the top level and the round-robin arbiter.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width for n channels, never narrower than one bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_stream_rr_arbiter.sv
// Round-robin arbiter: rotating priority scan starting at ptr.
// ptr moves just past the winner on each accepted grant.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_valid,
  input  logic            i_advance,
  output logic [SELW-1:0] o_grant,
  output logic            o_grant_valid
);

  logic [SELW-1:0] r_ptr;
  int              w_idx;

  // Scan from farthest to nearest so the nearest hit wins
  always_comb begin
    o_grant = '0;
    w_idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (i_valid[w_idx]) o_grant = SELW'(w_idx);
    end
  end

  assign o_grant_valid = |i_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant == SELW'(N - 1)) ? '0
             : o_grant + 1'b1;
    end
  end

endmodule

// File: rtl/mux_stream.sv
// N-channel registered stream mux, external select or round-robin.
// One output register; drain and refill share the same edge.
module mux_stream
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int MODE  = 0,
  localparam int SELW  = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             w_load_en;
  logic             w_gnt_valid;
  logic [SELW-1:0]  w_gnt;
  logic [WIDTH-1:0] w_gnt_data;

  assign w_load_en = !out_valid || out_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(.N(N)) u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (in_valid),
        .i_advance     (w_load_en && w_gnt_valid),
        .o_grant       (w_gnt),
        .o_grant_valid (w_gnt_valid)
      );
    end else begin : g_sel
      logic w_hit;
      // Out-of-range select values match no channel
      always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < N; i++)
          if (sel == SELW'(i)) w_hit = in_valid[i];
      end
      assign w_gnt       = sel;
      assign w_gnt_valid = w_hit;
    end
  endgenerate

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N; i++)
      if (w_gnt == SELW'(i))
        w_gnt_data = in_data[i*WIDTH +: WIDTH];
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++)
      in_ready[i] = w_load_en && w_gnt_valid
                 && (w_gnt == SELW'(i)) && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (w_load_en) begin
      if (w_gnt_valid) begin
        out_valid <= 1'b1;
        out_data  <= w_gnt_data;
        out_src   <= w_gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream.sv
// Bench for mux_stream: one select-mode and one round-robin instance
// checked every cycle against a queue-free transfer model.
module tb_mux_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data [2];
  logic [3:0]  s_valid[2];
  logic [1:0]  s_sel  [2];
  logic        s_ordy [2];
  logic [3:0]  o_rdy  [2];
  logic [7:0]  o_dat  [2];
  logic [1:0]  o_src  [2];
  logic        o_vld  [2];

  int total = 0;
  int bad   = 0;

  int m_valid[2];
  int m_data [2];
  int m_src  [2];
  int m_ptr  [2];

  always #5 clk = ~clk;

  mux_stream #(.WIDTH(8), .N(4), .MODE(0)) u0 (
    .clk(clk), .rst(rst),
    .in_data(s_data[0]), .in_valid(s_valid[0]),
    .in_ready(o_rdy[0]), .sel(s_sel[0]),
    .out_data(o_dat[0]), .out_src(o_src[0]),
    .out_valid(o_vld[0]), .out_ready(s_ordy[0])
  );

  mux_stream #(.WIDTH(8), .N(4), .MODE(1)) u1 (
    .clk(clk), .rst(rst),
    .in_data(s_data[1]), .in_valid(s_valid[1]),
    .in_ready(o_rdy[1]), .sel(s_sel[1]),
    .out_data(o_dat[1]), .out_src(o_src[1]),
    .out_valid(o_vld[1]), .out_ready(s_ordy[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // d=0 follows the select rule, d=1 walks channels from ptr with wrap
  task automatic mgrant(input int d, output int g, output int gv);
    g  = 0;
    gv = 0;
    if (d == 0) begin
      g  = int'(s_sel[0]);
      gv = int'(s_valid[0][g]);
    end else begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr[1] + k) % 4;
        if (gv == 0 && s_valid[1][i]) begin
          g  = i;
          gv = 1;
        end
      end
    end
  endtask

  function automatic int m_le(input int d);
    return (m_valid[d] == 0 || s_ordy[d]) ? 1 : 0;
  endfunction

  task automatic exp_rdy(input int d, output int r);
    int g, gv;
    mgrant(d, g, gv);
    r = (!rst && gv == 1 && m_le(d) == 1) ? (1 << g) : 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_valid[d] = 0; m_data[d] = 0;
        m_src[d] = 0;   m_ptr[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int g, gv;
        mgrant(d, g, gv);
        if (m_le(d) == 1) begin
          if (gv == 1) begin
            m_valid[d] = 1;
            m_data[d]  = int'((s_data[d] >> (8 * g)) & 32'hFF);
            m_src[d]   = g;
            if (d == 1) m_ptr[d] = (g + 1) % 4;
          end else begin
            m_valid[d] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int r;
      exp_rdy(d, r);
      chk($sformatf("cyc%0d in_ready", d), int'(o_rdy[d]), r);
      chk($sformatf("cyc%0d out_valid", d), int'(o_vld[d]), m_valid[d]);
      chk($sformatf("cyc%0d out_data", d), int'(o_dat[d]), m_data[d]);
      chk($sformatf("cyc%0d out_src", d), int'(o_src[d]), m_src[d]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_exp[6];
    rr_exp = '{0, 1, 2, 3, 0, 1};
    for (int d = 0; d < 2; d++) begin
      s_data[d] = '0; s_valid[d] = '0;
      s_sel[d] = '0;  s_ordy[d] = 1'b1;
    end
    #2;
    chk("rst out_valid", int'(o_vld[0]), 0);
    chk("rst in_ready", int'(o_rdy[1]), 0);
    step(); step();
    rst = 1'b0;

    // select mode: channel 2 carries A5
    s_sel[0] = 2'd2; s_valid[0] = 4'b0100;
    s_data[0] = 32'h00A5_0000;
    #1 chk("sel2 in_ready", int'(o_rdy[0]), 4);
    step();
    chk("sel2 out_data", int'(o_dat[0]), 8'hA5);
    chk("sel2 out_src", int'(o_src[0]), 2);
    chk("sel2 out_valid", int'(o_vld[0]), 1);
    s_valid[0] = 4'b0000;
    step();
    chk("sel2 idle", int'(o_vld[0]), 0);

    // select miss after a held word
    s_valid[0] = 4'b0100;
    step();
    s_sel[0] = 2'd1; s_ordy[0] = 1'b0;
    step();
    chk("miss held", int'(o_vld[0]), 1);
    s_ordy[0] = 1'b1;
    #1 chk("miss in_ready", int'(o_rdy[0]), 0);
    step();
    chk("miss drained", int'(o_vld[0]), 0);

    // round-robin, all channels valid
    s_data[1] = 32'h1312_1110; s_valid[1] = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rr seq%0d", i), int'(o_src[1]), rr_exp[i]);
    end
    chk("rr data", int'(o_dat[1]), 8'h11);

    // backpressure holds everything, ptr stays at 2
    s_ordy[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp in_ready", int'(o_rdy[1]), 0);
      step();
      chk("bp src", int'(o_src[1]), 1);
      chk("bp data", int'(o_dat[1]), 8'h11);
    end
    s_ordy[1] = 1'b1; s_valid[1] = 4'b1010;
    #1 chk("bp release rdy", int'(o_rdy[1]), 8);
    step();
    chk("bp release src", int'(o_src[1]), 3);
    chk("bp release data", int'(o_dat[1]), 8'h13);

    // sparse: reach ptr=3, then lone request on channel 1
    s_valid[1] = 4'b0100;
    step();
    chk("sparse pre src", int'(o_src[1]), 2);
    s_valid[1] = 4'b0010;
    step();
    chk("sparse src", int'(o_src[1]), 1);
    s_valid[1] = 4'b0101;
    step();
    chk("sparse ptr2", int'(o_src[1]), 2);

    // asynchronous reset while full
    chk("pre-rst full", int'(o_vld[1]), 1);
    rst = 1'b1;
    #1;
    chk("arst valid", int'(o_vld[1]), 0);
    chk("arst data", int'(o_dat[1]), 0);
    chk("arst src", int'(o_src[1]), 0);
    chk("arst ready", int'(o_rdy[1]), 0);
    step();
    chk("rst hold ready", int'(o_rdy[1]), 0);
    rst = 1'b0;
    #1 chk("post-rst rdy", int'(o_rdy[1]), 1);
    step();
    chk("post-rst src0", int'(o_src[1]), 0);
    step();
    chk("post-rst src2", int'(o_src[1]), 2);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
